// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: blanking patterns,
// the active-low hex segment table and the slot-state encoding.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low, bit order gfedcba; index is the nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    GHOST = 1'b0,
    DRIVE = 1'b1
  } slot_state_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/io_seg7_scan.sv
// 8-digit common-anode seven-segment scanner with frame-synchronous shadow
// latch and per-slot ghost interval. Define SEG7_BLANK_EN for leading-zero blanking.
//
// state | meaning
// GHOST | start of a digit slot, all anodes off to hide segment switching
// DRIVE | remainder of the slot, current digit anode and segments driven
module io_seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV_WIDTH = 16,
  parameter int DIV_MAX   = 49999,
  parameter int GHOST_CYC = 2500
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam logic [DIV_WIDTH-1:0] DIV_TC    = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH:0]   GHOST_LIM = (DIV_WIDTH+1)'(GHOST_CYC);

  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH:0]   presc_inc;
  logic [2:0]           idx;
  logic [31:0]          shadow_data;
  logic [7:0]           shadow_dp;
  logic                 tick;
  logic                 boundary;
  slot_state_e          slot_state;
  logic [3:0]           nibble;
  logic [6:0]           hex_seg;
  logic                 blank;
  logic [7:0]           an_nxt;
  logic [6:0]           seg_nxt;
  logic                 dp_nxt;

  assign tick      = (presc == DIV_TC);
  assign boundary  = tick && (idx == 3'd7);
  assign presc_inc = {1'b0, presc} + 1'b1;
  assign nibble    = shadow_data[{idx, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

`ifdef SEG7_BLANK_EN
  // Blank when this nibble and all higher ones are zero; digit 0 always shows
  assign blank = (idx != 3'd0) && ((shadow_data >> {idx, 2'b00}) == 32'h0);
`else
  assign blank = 1'b0;
`endif

  // p < GHOST_CYC written as p+1 <= GHOST_CYC so GHOST_CYC=0 needs no special case
  always_comb begin
    slot_state = DRIVE;
    if (presc_inc <= GHOST_LIM) slot_state = GHOST;
  end

  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (slot_state == DRIVE) begin
      an_nxt  = ~(8'b1 << idx);
      seg_nxt = blank ? SEG_OFF : hex_seg;
      dp_nxt  = blank | ~shadow_dp[idx];
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      presc       <= '0;
      idx         <= 3'd0;
      shadow_data <= 32'h0;
      shadow_dp   <= 8'h0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc_inc[DIV_WIDTH-1:0];
      frame_done <= boundary;
      if (tick) idx <= idx + 3'd1;
      if (boundary) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule
